// File: rtl/mac_header_inserter_if.sv
// Avalon-ST beat bundle with a ready/valid handshake.
// master drives the beat; slave returns ready.
interface mac_header_inserter_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2
);
  logic [DATA_WIDTH-1:0]  data;
  logic                   valid;
  logic                   sop;
  logic                   eop;
  logic [EMPTY_WIDTH-1:0] empty;
  logic                   ready;

  modport master (
    output data,
    output valid,
    output sop,
    output eop,
    output empty,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  sop,
    input  eop,
    input  empty,
    output ready
  );
endinterface

// File: rtl/mac_header_inserter.sv
// Transmit-path framer: prepends {dest, src} MAC header
// to each Avalon-ST packet from the payload engine.
module mac_header_inserter #(
  parameter int DATA_WIDTH     = 32,
  parameter int EMPTY_WIDTH    = 2,
  parameter int MAC_ADDR_WIDTH = 48,
  parameter int HEADER_SIZE    = 96
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MAC_ADDR_WIDTH-1:0] dest_mac_addr,
  input  logic [MAC_ADDR_WIDTH-1:0] source_mac_addr,
  mac_header_inserter_if.slave      in_st,
  mac_header_inserter_if.master     out_st,
  output logic [15:0]               pkt_count,
  output logic [15:0]               drop_count,
  output logic [15:0]               err_count
);

  localparam int HEADER_WORDS = HEADER_SIZE / DATA_WIDTH;
  localparam int CNT_W =
    (HEADER_WORDS > 1) ? $clog2(HEADER_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD =
    CNT_W'(HEADER_WORDS - 1);

  generate
    if ((HEADER_SIZE % DATA_WIDTH) != 0 ||
        HEADER_SIZE != 2 * MAC_ADDR_WIDTH) begin : g_bad_cfg
      $error("HEADER_SIZE must be 2*MAC and a DATA_WIDTH multiple");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    HOLD,
    PAYLOAD
  } state_t;

  state_t                 state;
  state_t                 state_n;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_n;
  logic [HEADER_SIZE-1:0] hdr;
  logic [DATA_WIDTH-1:0]  hold_data;
  logic                   hold_eop;
  logic [EMPTY_WIDTH-1:0] hold_empty;

  logic latch;
  logic hdr_shift;
  logic drop_ev;
  logic err_ev;
  logic pkt_ev;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    latch        = 1'b0;
    hdr_shift    = 1'b0;
    drop_ev      = 1'b0;
    err_ev       = 1'b0;
    pkt_ev       = 1'b0;
    in_st.ready  = 1'b0;
    out_st.valid = 1'b0;
    out_st.data  = '0;
    out_st.sop   = 1'b0;
    out_st.eop   = 1'b0;
    out_st.empty = '0;
    unique case (state)
      IDLE: begin
        in_st.ready = 1'b1;
        if (in_st.valid) begin
          if (in_st.sop) begin
            latch   = 1'b1;
            cnt_n   = '0;
            state_n = HEADER;
          end else begin
            drop_ev = 1'b1;
          end
        end
      end
      HEADER: begin
        out_st.valid = 1'b1;
        out_st.data  = hdr[HEADER_SIZE-1 -: DATA_WIDTH];
        out_st.sop   = (cnt == '0);
        if (out_st.ready) begin
          hdr_shift = 1'b1;
          if (cnt == LAST_WORD) begin
            state_n = HOLD;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        out_st.valid = 1'b1;
        out_st.data  = hold_data;
        out_st.eop   = hold_eop;
        out_st.empty = hold_eop ? hold_empty : '0;
        if (out_st.ready) begin
          if (hold_eop) begin
            pkt_ev  = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        in_st.ready  = out_st.ready;
        out_st.valid = in_st.valid;
        // gate with valid so an idle upstream never leaks X
        if (in_st.valid) begin
          out_st.data  = in_st.data;
          out_st.eop   = in_st.eop;
          out_st.empty = in_st.eop ? in_st.empty : '0;
          if (out_st.ready) begin
            err_ev = in_st.sop;
            if (in_st.eop) begin
              pkt_ev  = 1'b1;
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hdr        <= '0;
      hold_data  <= '0;
      hold_eop   <= 1'b0;
      hold_empty <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch) begin
        hdr        <= {dest_mac_addr, source_mac_addr};
        hold_data  <= in_st.data;
        hold_eop   <= in_st.eop;
        hold_empty <= in_st.empty;
      end else if (hdr_shift) begin
        hdr <= hdr << DATA_WIDTH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count  <= '0;
      drop_count <= '0;
      err_count  <= '0;
    end else begin
      if (pkt_ev) pkt_count <= pkt_count + 16'd1;
      if (drop_ev) drop_count <= drop_count + 16'd1;
      if (err_ev) err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mac_header_inserter.sv
// Randomized bench for mac_header_inserter against a
// packet-level reference model.
module tb_mac_header_inserter;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] dest;
  logic [47:0] src;
  logic [15:0] pkt_count;
  logic [15:0] drop_count;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  mac_header_inserter_if in_st ();
  mac_header_inserter_if out_st ();

  mac_header_inserter dut (
    .clk             (clk),
    .rst             (rst),
    .dest_mac_addr   (dest),
    .source_mac_addr (src),
    .in_st           (in_st),
    .out_st          (out_st),
    .pkt_count       (pkt_count),
    .drop_count      (drop_count),
    .err_count       (err_count)
  );

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        e;
    logic [1:0]  em;
  } beat_t;

  beat_t       q[$];
  bit          in_pkt;
  logic [15:0] exp_pkt;
  logic [15:0] exp_drop;
  logic [15:0] exp_err;
  int          stall_mode;
  bit          churn;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag,
                       input logic [47:0] got,
                       input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    in_pkt   = 0;
    exp_pkt  = '0;
    exp_drop = '0;
    exp_err  = '0;
  endtask

  task automatic model_accept(input logic [31:0] d,
                              input logic s,
                              input logic e,
                              input logic [1:0] em);
    logic [95:0] h;
    if (!in_pkt) begin
      if (s) begin
        h = {dest, src};
        for (int k = 0; k < 3; k++)
          q.push_back('{d: h[95-32*k -: 32], s: (k == 0),
                        e: 1'b0, em: 2'd0});
        q.push_back('{d: d, s: 1'b0, e: e,
                      em: e ? em : 2'd0});
        if (e) exp_pkt++;
        else in_pkt = 1;
      end else begin
        exp_drop++;
      end
    end else begin
      if (s) exp_err++;
      q.push_back('{d: d, s: 1'b0, e: e, em: e ? em : 2'd0});
      if (e) begin
        exp_pkt++;
        in_pkt = 0;
      end
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_pkt"}, 48'(pkt_count), 48'(exp_pkt));
    check({tag, "_drop"}, 48'(drop_count), 48'(exp_drop));
    check({tag, "_err"}, 48'(err_count), 48'(exp_err));
  endtask

  // one cycle: drive out_ready, sample just before posedge
  task automatic tick(output bit acc);
    bit    exp_rdy;
    bit    exp_vld;
    int    had;
    beat_t f;
    case (stall_mode)
      0: out_st.ready = 1'b1;
      1: out_st.ready = ~out_st.ready;
      default: out_st.ready = ($urandom_range(3) != 0);
    endcase
    if (churn && $urandom_range(3) == 0) begin
      dest = {16'($urandom), 32'($urandom)};
      src  = {16'($urandom), 32'($urandom)};
    end
    #1;
    had     = q.size();
    exp_rdy = (had != 0) ? 1'b0 : (in_pkt ? out_st.ready : 1'b1);
    exp_vld = (had != 0) ? 1'b1 : (in_pkt ? in_st.valid : 1'b0);
    check("ctl", {46'd0, in_st.ready, out_st.valid},
          {46'd0, exp_rdy, exp_vld});
    acc = in_st.valid && in_st.ready;
    if (acc)
      model_accept(in_st.data, in_st.sop, in_st.eop, in_st.empty);
    if (out_st.valid && out_st.ready) begin
      check("extra_beat", 48'(q.size() != 0), 48'd1);
      if (q.size() != 0) begin
        f = q.pop_front();
        check("beat", {out_st.sop, out_st.eop, out_st.empty,
                       out_st.data}, {f.s, f.e, f.em, f.d});
      end
    end else if (out_st.valid && had != 0) begin
      f = q[0];
      check("stall", {out_st.sop, out_st.eop, out_st.empty,
                      out_st.data}, {f.s, f.e, f.em, f.d});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) tick(acc);
  endtask

  task automatic send_beat(input logic [31:0] d,
                           input logic s,
                           input logic e,
                           input logic [1:0] em);
    bit acc;
    int n;
    in_st.data  = d;
    in_st.sop   = s;
    in_st.eop   = e;
    in_st.empty = em;
    in_st.valid = 1'b1;
    n = 0;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 100);
    check("accept", 48'(acc), 48'd1);
    in_st.valid = 1'b0;
    in_st.data  = '0;
    in_st.sop   = 1'b0;
    in_st.eop   = 1'b0;
    in_st.empty = '0;
  endtask

  task automatic send_pkt(input int n, input int sop_idx);
    for (int i = 0; i < n; i++)
      send_beat($urandom, (i == 0) || (i == sop_idx),
                (i == n - 1), 2'($urandom_range(3)));
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      tick(acc);
      n++;
    end
    check("drain", 48'(q.size()), 48'd0);
  endtask

  task automatic reset_now();
    rst = 1'b1;
    #1;
    model_clear();
    check("rst_out", {out_st.valid, out_st.sop, out_st.eop,
                      out_st.empty, out_st.data}, 48'd0);
    check("rst_ready", 48'(in_st.ready), 48'd1);
    check_counts("rst");
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    in_st.valid  = 1'b0;
    in_st.data   = '0;
    in_st.sop    = 1'b0;
    in_st.eop    = 1'b0;
    in_st.empty  = '0;
    out_st.ready = 1'b1;
    dest         = 48'h001122334455;
    src          = 48'h66778899AABB;
    stall_mode   = 0;
    churn        = 0;
    model_clear();
    @(negedge clk);
    reset_now();
    idle(1);

    // two-beat packet, documented header words
    send_beat(32'hDEADBEEF, 1'b1, 1'b0, 2'd0);
    send_beat(32'hCAFEF00D, 1'b0, 1'b1, 2'd2);
    drain();
    check_counts("t1");

    // single beat packet, sop and eop together
    send_beat(32'h12345678, 1'b1, 1'b1, 2'd1);
    drain();
    idle(1);
    #1;
    check("t2_ready", 48'(in_st.ready), 48'd1);
    @(negedge clk);
    check_counts("t2");

    // alternating backpressure
    stall_mode = 1;
    send_pkt(3, -1);
    drain();
    stall_mode = 0;
    check_counts("t3");

    // stray beats in idle
    for (int i = 0; i < 3; i++)
      send_beat($urandom, 1'b0, (i == 1), 2'd3);
    send_pkt(2, -1);
    drain();
    check_counts("t4");

    // sop inside a packet
    send_pkt(4, 2);
    drain();
    check_counts("t5");

    // MAC change mid packet, then reset in payload
    send_beat(32'hA5A5A5A5, 1'b1, 1'b0, 2'd0);
    dest = 48'hFEDCBA987654;
    send_beat(32'h5A5A5A5A, 1'b0, 1'b0, 2'd0);
    drain();
    reset_now();
    send_pkt(2, -1);
    drain();
    check_counts("t6");

    // randomized traffic
    stall_mode = 2;
    churn      = 1;
    for (int p = 0; p < 60; p++) begin
      if ($urandom_range(9) == 0)
        send_beat($urandom, 1'b0, 1'($urandom), 2'($urandom));
      send_pkt(int'($urandom_range(1, 6)),
               ($urandom_range(9) == 0) ? 1 : -1);
      idle(int'($urandom_range(0, 2)));
    end
    drain();
    check_counts("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_header_inserter.md
Name: mac_header_inserter

Overview:
- Transmit-path stage, directly downstream of the payload engine and upstream of the transmit stream output.
- Mirror of the receive-side header removal: prepends the MAC header {dest_mac_addr, source_mac_addr} to every outgoing Avalon-ST packet.
- Header fields come from the register controller and are latched per packet.
- Streams are 32-bit Avalon-ST with sop/eop/empty and a ready/valid handshake.

Parameters:
- DATA_WIDTH, 32: stream data width in bits.
- EMPTY_WIDTH, 2: width of the empty field, log2(DATA_WIDTH/8).
- MAC_ADDR_WIDTH, 48: width of one MAC address.
- HEADER_SIZE, 96: header bits, 2*MAC_ADDR_WIDTH. Must be a multiple of DATA_WIDTH, checked by elaboration assertion. HEADER_WORDS = HEADER_SIZE/DATA_WIDTH (3).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- dest_mac_addr  in  MAC_ADDR_WIDTH  destination MAC from the register controller.
- source_mac_addr  in  MAC_ADDR_WIDTH  source MAC from the register controller.
- in_data  in  DATA_WIDTH  payload stream data.
- in_valid  in  1  payload beat valid.
- in_sop  in  1  payload start of packet.
- in_eop  in  1  payload end of packet.
- in_empty  in  EMPTY_WIDTH  empty bytes on the eop beat.
- in_ready  out  1  block accepts a payload beat.
- out_data  out  DATA_WIDTH  framed stream data.
- out_valid  out  1  framed beat valid.
- out_sop  out  1  framed start of packet.
- out_eop  out  1  framed end of packet.
- out_empty  out  EMPTY_WIDTH  framed empty bytes, non-zero only with out_eop.
- out_ready  in  1  downstream accepts.
- pkt_count  out  16  framed packets completed; wraps.
- drop_count  out  16  input beats discarded outside a packet; wraps.
- err_count  out  16  sop beats seen inside a packet; wraps.

Behaviour:
- Beat transfer: in-beat when in_valid & in_ready; out-beat when out_valid & out_ready.
- Reset (async, rst=1):
  - state = IDLE; word counter = 0; hold and header registers = 0; all counters = 0.
  - Outputs during and after reset: in_ready=1 (IDLE), out_valid=0, out_sop=0, out_eop=0, out_empty=0, out_data=0.
  - Reset mid-packet abandons the packet; no eop is emitted for it.
- State machine: IDLE, HEADER, HOLD, PAYLOAD.
- IDLE:
  - in_ready=1, out_valid=0.
  - In-beat with in_sop=1: latch hdr={dest_mac_addr, source_mac_addr}; capture in_data/in_eop/in_empty into hold regs; word counter=0; go HEADER.
  - In-beat with in_sop=0: discarded; drop_count++; stay IDLE.
- HEADER:
  - in_ready=0, out_valid=1.
  - out_data = hdr[HEADER_SIZE-1-k*DATA_WIDTH -: DATA_WIDTH], where k = word counter.
  - out_sop = (k==0); out_eop=0; out_empty=0.
  - Each out-beat: k++. The out-beat at k==HEADER_WORDS-1 moves to HOLD.
  - Default word order: word0=dest[47:16], word1={dest[15:0],src[47:32]}, word2=src[31:0].
- HOLD:
  - in_ready=0, out_valid=1.
  - out_data = held data; out_sop=0; out_eop = held eop; out_empty = held eop ? held empty : 0.
  - On out-beat: held eop=1 → pkt_count++, go IDLE; otherwise go PAYLOAD.
- PAYLOAD (combinational pass-through):
  - out_valid=in_valid; in_ready=out_ready; out_data=in_data; out_sop=0.
  - out_eop=in_eop; out_empty = in_eop ? in_empty : 0.
  - In-beat with in_eop=1 → pkt_count++, go IDLE.
  - In-beat with in_sop=1 → sop stripped, beat forwarded, err_count++.
- Latency:
  - First header word is valid the cycle after the sop in-beat.
  - With out_ready held at 1, a packet of N payload beats takes 1 (sop) + HEADER_WORDS + N cycles on the output side, plus 1 idle turnaround cycle before the next sop is accepted.
- Header latching: hdr is captured only at sop acceptance. MAC input changes mid-packet affect the next packet only.
- out_ready=0 in HEADER/HOLD: out_data/out_sop/out_eop/out_empty held stable, counters frozen.
- Header output is independent of in_valid (header words are sourced internally).
- Single-beat packet (sop & eop together): header words, then the HOLD beat carrying eop; PAYLOAD is never entered.
- Counters wrap 0xFFFF → 0x0000.
- Contract with the upstream stage: no X on out_* when out_valid=0 in PAYLOAD. Upstream drives data only with valid.

Test Plan:
- dest=0x001122334455, src=0x66778899AABB; 2-beat packet 0xDEADBEEF (sop), 0xCAFEF00D (eop, empty=2); out_ready=1 → out beats 0x00112233 (sop), 0x445566 77, 0x8899AABB, 0xDEADBEEF, 0xCAFEF00D (eop, empty=2); pkt_count=1.
- Single-beat packet 0x12345678 (sop & eop, empty=1) → 3 header words then 0x12345678 with eop, empty=1; returns to IDLE; in_ready=1 next cycle.
- out_ready toggled 1,0,1,0 through the header and payload → every word delivered exactly once, in order, stable while stalled; in_ready=0 throughout HEADER/HOLD.
- 3 non-sop beats in IDLE, then a valid packet → drop_count=3; packet framed correctly.
- sop asserted on beat 3 of a 4-beat packet → out_sop only on header word0; err_count=1; pkt_count=1.
- dest_mac_addr changed after sop acceptance, then rst pulsed mid-PAYLOAD → header keeps the old MAC; after reset all counters=0, out_valid=0, in_ready=1; the next packet carries the new MAC.
